rvv_backend_xrf_wb_sched: RTL and testbench

Scheduler between the retire stage's 4 XRF write lanes and the scalar core's single XRF write port. It accepts up to 4 in-order XRF writebacks per cycle into a small circular buffer. It drains them one per cycle to the scalar XRF over a valid/ready handshake, in program order. Retire lanes get per-lane ready back, which gates retire of XRF-type uops.

---
 rtl/rvv_backend_xrf_wb_sched.sv | 124 ++++++++++++
 tb/tb_rvv_backend_xrf_wb_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvv_backend_xrf_wb_sched.sv
// XRF writeback scheduler: buffers up to NUM_LANE in-order retire XRF writes
// per cycle and drains them one per cycle to the scalar XRF port.
// Ports: clk/rst (sync, active-high); rt_xrf_valid/index/data in, rt_xrf_ready
// out (per lane); xrf_wb_valid/index/data out, xrf_wb_ready in;
// wb_pending_cnt/wb_busy report occupancy.
// Optional macro RVV_XRF_WB_BYPASS_EN: same-cycle bypass of the lowest valid
// lane to xrf_wb_* when the buffer is empty.
module rvv_backend_xrf_wb_sched #(
    parameter int NUM_LANE = 4,
    parameter int DEPTH    = 8,
    parameter int XLEN     = 32,
    parameter int IDX_W    = 5,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_LANE-1:0]       rt_xrf_valid,
    input  logic [NUM_LANE*IDX_W-1:0] rt_xrf_index,
    input  logic [NUM_LANE*XLEN-1:0]  rt_xrf_data,
    output logic [NUM_LANE-1:0]       rt_xrf_ready,
    output logic                      xrf_wb_valid,
    output logic [IDX_W-1:0]          xrf_wb_index,
    output logic [XLEN-1:0]           xrf_wb_data,
    input  logic                      xrf_wb_ready,
    output logic [CNT_W-1:0]          wb_pending_cnt,
    output logic                      wb_busy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0] idx_q  [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0]    free;
    logic [CNT_W-1:0]    need;
    logic [CNT_W-1:0]    npush;
    logic [NUM_LANE-1:0] push_en;
    logic [PTR_W-1:0]    slot [NUM_LANE];
    logic [NUM_LANE-1:0] byp_sel;
    logic                byp_any;
    logic                byp_take;
    logic                pop;

    // Credit comes from the registered count only; a same-cycle pop
    // never frees a slot for this cycle's pushes.
    always_comb begin
        free     = CNT_W'(DEPTH) - count_q;
        byp_sel  = '0;
`ifdef RVV_XRF_WB_BYPASS_EN
        if (!rst && count_q == '0) begin
            for (int i = NUM_LANE - 1; i >= 0; i--) begin
                if (rt_xrf_valid[i]) byp_sel = NUM_LANE'(1) << i;
            end
        end
`endif
        byp_any  = |byp_sel;
        byp_take = byp_any && xrf_wb_ready;
        need     = '0;
        npush    = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            // A lane consumed by the bypass neither uses credit nor a slot.
            if (rt_xrf_valid[i] && !(byp_take && byp_sel[i])) begin
                need = need + CNT_W'(1);
            end
            rt_xrf_ready[i] = !rst && (need <= free);
            push_en[i] = rt_xrf_valid[i] && rt_xrf_ready[i]
                         && !(byp_take && byp_sel[i]);
            slot[i] = wr_ptr_q + PTR_W'(npush);
            if (push_en[i]) npush = npush + CNT_W'(1);
        end
    end

    always_comb begin
        xrf_wb_valid = (count_q != '0);
        xrf_wb_index = idx_q[rd_ptr_q];
        xrf_wb_data  = data_q[rd_ptr_q];
`ifdef RVV_XRF_WB_BYPASS_EN
        if (byp_any) begin
            xrf_wb_valid = 1'b1;
            for (int i = 0; i < NUM_LANE; i++) begin
                if (byp_sel[i]) begin
                    xrf_wb_index = rt_xrf_index[i*IDX_W +: IDX_W];
                    xrf_wb_data  = rt_xrf_data[i*XLEN +: XLEN];
                end
            end
        end
`endif
    end

    assign pop      = (count_q != '0) && xrf_wb_ready;
    assign wr_ptr_d = wr_ptr_q + PTR_W'(npush);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign count_d  = count_q + npush - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; entries are only read when counted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANE; i++) begin
            if (push_en[i]) begin
                idx_q[slot[i]]  <= rt_xrf_index[i*IDX_W +: IDX_W];
                data_q[slot[i]] <= rt_xrf_data[i*XLEN +: XLEN];
            end
        end
    end

    assign wb_pending_cnt = count_q;
    assign wb_busy        = (count_q != '0);

endmodule

// File: tb/tb_rvv_backend_xrf_wb_sched.sv
// Self-checking bench for rvv_backend_xrf_wb_sched: directed vector table,
// reset/latency sequences and randomized traffic against a queue model.
module tb_rvv_backend_xrf_wb_sched;

    localparam int NL = 4;
    localparam int D  = 8;
    localparam int XL = 32;
    localparam int IW = 5;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NL-1:0]  v;
    logic [NL*IW-1:0] idx;
    logic [NL*XL-1:0] dat;
    logic [NL-1:0]  rdy;
    logic           wv;
    logic [IW-1:0]  wi;
    logic [XL-1:0]  wd;
    logic           wr;
    logic [CW-1:0]  cnt;
    logic           busy;

    int errs = 0;
    int checks = 0;

    rvv_backend_xrf_wb_sched dut (
        .clk(clk), .rst(rst),
        .rt_xrf_valid(v), .rt_xrf_index(idx), .rt_xrf_data(dat),
        .rt_xrf_ready(rdy),
        .xrf_wb_valid(wv), .xrf_wb_index(wi), .xrf_wb_data(wd),
        .xrf_wb_ready(wr),
        .wb_pending_cnt(cnt), .wb_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 2ns later.
    task automatic cyc(input logic r, input logic [NL-1:0] vv,
                       input logic [NL*IW-1:0] ii, input logic ww);
        @(negedge clk);
        rst = r;
        v   = vv;
        idx = ii;
        wr  = ww;
        for (int l = 0; l < NL; l++)
            dat[l*XL +: XL] = 32'hC0DE_0000 | XL'(ii[l*IW +: IW]);
        #2;
    endtask

    function automatic logic [NL*IW-1:0] pk(int a, int b, int c, int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    typedef struct {
        logic [NL-1:0]    v;
        logic [NL*IW-1:0] idx;
        logic             wr;
        logic [NL-1:0]    er;
        logic             ev;
        logic [IW-1:0]    ei;
        logic [CW-1:0]    ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [NL-1:0] a, logic [NL*IW-1:0] b,
                                logic c, logic [NL-1:0] e, logic f,
                                int g, int h);
        vec_t t;
        t.v = a; t.idx = b; t.wr = c; t.er = e;
        t.ev = f; t.ei = IW'(g); t.ec = CW'(h);
        tbl.push_back(t);
    endfunction

    typedef struct {
        logic [IW-1:0] i;
        logic [XL-1:0] d;
    } ent_t;

    ent_t q[$];

    initial begin
        int fr[8];
        logic [NL*IW-1:0] p12;
        logic [NL*IW-1:0] p79;
        rst = 1'b1; v = '0; idx = '0; dat = '0; wr = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_ready", 64'(rdy), 64'h0);
        chk("rst_wbv", 64'(wv), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

`ifndef RVV_XRF_WB_BYPASS_EN
        p12 = pk(12, 13, 14, 15);
        p79 = pk(0, 7, 0, 9);
        add(4'b1111, pk(1, 2, 3, 4), 1, 4'b1111, 0, 0, 0);
        add(4'b0000, 0, 1, 4'b1111, 1, 1, 4);
        add(4'b0000, 0, 1, 4'b1111, 1, 2, 3);
        add(4'b0000, 0, 1, 4'b1111, 1, 3, 2);
        add(4'b0000, 0, 1, 4'b1111, 1, 4, 1);
        add(4'b0000, 0, 1, 4'b1111, 0, 0, 0);
        add(4'b1111, pk(5, 6, 7, 8), 0, 4'b1111, 0, 0, 0);
        add(4'b0111, pk(9, 10, 11, 0), 0, 4'b1111, 1, 5, 4);
        add(4'b1111, p12, 0, 4'b0001, 1, 5, 7);
        add(4'b1110, p12, 0, 4'b0001, 1, 5, 8);
        add(4'b1110, p12, 1, 4'b0001, 1, 5, 8);
        add(4'b1110, p12, 0, 4'b0011, 1, 6, 7);
        add(4'b1100, p12, 1, 4'b0011, 1, 6, 8);
        add(4'b1100, p12, 0, 4'b0111, 1, 7, 7);
        add(4'b1000, p12, 1, 4'b0111, 1, 7, 8);
        add(4'b1000, p12, 1, 4'b1111, 1, 8, 7);
        add(4'b1010, p79, 0, 4'b0111, 1, 9, 7);
        add(4'b1000, p79, 1, 4'b0111, 1, 9, 8);
        add(4'b1000, p79, 0, 4'b1111, 1, 10, 7);
        fr = '{10, 11, 12, 13, 14, 15, 7, 9};
        for (int k = 0; k < 8; k++)
            add(4'b0000, 0, 1, 4'b1111, 1, fr[k], 8 - k);
        add(4'b0000, 0, 1, 4'b1111, 0, 0, 0);

        foreach (tbl[n]) begin
            cyc(0, tbl[n].v, tbl[n].idx, tbl[n].wr);
            chk($sformatf("v%0d_ready", n), 64'(rdy), 64'(tbl[n].er));
            chk($sformatf("v%0d_wbv", n), 64'(wv), 64'(tbl[n].ev));
            chk($sformatf("v%0d_cnt", n), 64'(cnt), 64'(tbl[n].ec));
            chk($sformatf("v%0d_busy", n), 64'(busy), 64'(tbl[n].ec != 0));
            if (tbl[n].ev) begin
                chk($sformatf("v%0d_idx", n), 64'(wi), 64'(tbl[n].ei));
                chk($sformatf("v%0d_data", n), 64'(wd),
                    64'(32'hC0DE_0000 | XL'(tbl[n].ei)));
            end
        end
`endif

        // Reset mid-operation with five entries buffered
        cyc(0, 4'b1111, pk(1, 2, 3, 4), 0);
        cyc(0, 4'b0001, pk(5, 0, 0, 0), 0);
        cyc(0, 4'b0000, 0, 0);
        chk("mid_cnt5", 64'(cnt), 64'd5);
        cyc(1, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        chk("mid_wbv", 64'(wv), 64'h0);
        chk("mid_cnt", 64'(cnt), 64'h0);
        chk("mid_busy", 64'(busy), 64'h0);
        cyc(0, 4'b0001, pk(20, 0, 0, 0), 0);
        cyc(0, 4'b0000, 0, 1);
        chk("mid_first_wbv", 64'(wv), 64'h1);
        chk("mid_first_idx", 64'(wi), 64'd20);
        cyc(0, 4'b0000, 0, 1);
        chk("mid_drain_cnt", 64'(cnt), 64'h0);

        // Empty-buffer latency, lane 2 only
        @(negedge clk);
        rst = 0; v = 4'b0100; idx = pk(0, 0, 3, 0); wr = 1;
        dat = '0;
        dat[2*XL +: XL] = 32'hDEADBEEF;
        #2;
`ifdef RVV_XRF_WB_BYPASS_EN
        chk("lat_wbv0", 64'(wv), 64'h1);
        chk("lat_idx0", 64'(wi), 64'd3);
        chk("lat_dat0", 64'(wd), 64'hDEADBEEF);
        cyc(0, 4'b0000, 0, 1);
        chk("lat_cnt1", 64'(cnt), 64'h0);
        chk("lat_wbv1", 64'(wv), 64'h0);
`else
        chk("lat_wbv0", 64'(wv), 64'h0);
        cyc(0, 4'b0000, 0, 1);
        chk("lat_wbv1", 64'(wv), 64'h1);
        chk("lat_idx1", 64'(wi), 64'd3);
        chk("lat_dat1", 64'(wd), 64'hDEADBEEF);
        chk("lat_cnt1", 64'(cnt), 64'h1);
        cyc(0, 4'b0000, 0, 1);
        chk("lat_cnt2", 64'(cnt), 64'h0);
`endif

        // Randomized traffic against a queue model
        begin
            logic [NL-1:0] cv;
            logic [NL-1:0] er;
            logic [NL-1:0] acc;
            logic [NL*IW-1:0] ci;
            logic [NL*XL-1:0] cd;
            logic byp;
            logic take;
            int bl;
            int sz;
            int nd;
            cv = '0; ci = '0; cd = '0;
            q.delete();
            for (int c = 0; c < 600; c++) begin
                if (cv == '0) begin
                    cv = NL'($urandom_range(0, 15));
                    for (int l = 0; l < NL; l++) begin
                        ci[l*IW +: IW] = IW'($urandom);
                        cd[l*XL +: XL] = $urandom;
                    end
                end
                @(negedge clk);
                rst = 0; v = cv; idx = ci; dat = cd;
                wr = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 3) != 0);
                #2;
                sz = q.size();
                bl = 0;
                for (int l = NL - 1; l >= 0; l--) if (cv[l]) bl = l;
`ifdef RVV_XRF_WB_BYPASS_EN
                byp = (sz == 0) && (cv != 0);
`else
                byp = 1'b0;
`endif
                take = byp && wr;
                nd = 0;
                for (int l = 0; l < NL; l++) begin
                    if (cv[l] && !(take && l == bl)) nd++;
                    er[l] = (nd <= D - sz);
                end
                chk("rnd_ready", 64'(rdy), 64'(er));
                chk("rnd_wbv", 64'(wv), 64'((sz != 0) || byp));
                chk("rnd_cnt", 64'(cnt), 64'(sz));
                chk("rnd_busy", 64'(busy), 64'(sz != 0));
                if (sz != 0) begin
                    chk("rnd_idx", 64'(wi), 64'(q[0].i));
                    chk("rnd_data", 64'(wd), 64'(q[0].d));
                end else if (byp) begin
                    chk("rnd_byp_idx", 64'(wi), 64'(ci[bl*IW +: IW]));
                    chk("rnd_byp_data", 64'(wd), 64'(cd[bl*XL +: XL]));
                end
                if (sz != 0 && wr) void'(q.pop_front());
                acc = cv & er;
                for (int l = 0; l < NL; l++) begin
                    if (acc[l] && !(take && l == bl)) begin
                        ent_t e;
                        e.i = ci[l*IW +: IW];
                        e.d = cd[l*XL +: XL];
                        q.push_back(e);
                    end
                end
                cv = cv & ~acc;
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
